// File: rtl/scanner_receiver_pkg.sv
// scanner_receiver_pkg: state encodings and word width shared with the scanner transmitter
package scanner_receiver_pkg;
  localparam int DEF_DATA_WIDTH = 4;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RECV  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;
endpackage

// File: rtl/scanner_receiver_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser for a bus of slow async lines, rising-edge strobe on bit 0
// ports: clk, rst (async high) | din: raw lines | dout: synchronised lines | rise: 1-clk pulse on din[0] rising
module sync_edge_detect #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise
);
  logic [W-1:0] meta_q, sync_q;
  logic         last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      last_q <= sync_q[0];
    end
  assign dout = sync_q;
  assign rise = sync_q[0] & ~last_q;
endmodule

// File: rtl/scanner_receiver.sv
// scanner_receiver: deserialises the scanner link into DATA_WIDTH words with a ready/consume handshake
// ports: clk, rst (async high) | serialClkIn, serialDataIn: link from transmitter | consume: word taken
//        readyForTransferOut: transmitter may send | dataWord, dataValid: delivered word
//        frameError: timeout abort pulse | ps, bitCount: debug
module scanner_receiver
  import scanner_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serialClkIn,
  input  logic                  serialDataIn,
  input  logic                  consume,
  output logic                  readyForTransferOut,
  output logic [DATA_WIDTH-1:0] dataWord,
  output logic                  dataValid,
  output logic                  frameError,
  output logic [1:0]            ps,
  output logic [CNT_W-1:0]      bitCount
);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);
  logic [1:0] ser_sync;
  logic strobe;
  logic [1:0] ps_d, ps_q;
  logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q, bit_inc;
  logic [DATA_WIDTH-1:0] shift_d, shift_q, shift_in, word_d, word_q;
  logic valid_d, valid_q, ferr_d, ferr_q, rdy_d, rdy_q;
  logic [TMO_W-1:0] tmo_d, tmo_q;
  // data rides alongside the clock through the same synchroniser so both arrive aligned
  sync_edge_detect #(.W(2)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  ({serialDataIn, serialClkIn}),
    .dout (ser_sync),
    .rise (strobe)
  );
  assign shift_in = {shift_q[DATA_WIDTH-2:0], ser_sync[1]};
  assign bit_inc  = bit_cnt_q + CNT_W'(1);
  always_comb begin
    ps_d      = ps_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    tmo_d     = '0;
    case (ps_q)
      ST_IDLE:
        if (strobe) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_inc;
          ps_d      = ST_RECV;
        end
      ST_RECV:
        if (strobe && bit_inc == CNT_W'(DATA_WIDTH)) begin
          word_d    = shift_in;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          ps_d      = ST_FULL;
        end else if (strobe) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_inc;
        end else if (tmo_q == TMO_MAX) begin
          ferr_d    = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          ps_d      = ST_IDLE;
        end else tmo_d = tmo_q + TMO_W'(1);
      ST_FULL:
        if (consume) begin
          valid_d = 1'b0;
          ps_d    = ST_FLUSH;
        end
      default: ps_d = ST_IDLE;
    endcase
    // registered from next state so ready tracks ps exactly and is low out of reset
    rdy_d = ~ps_d[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ps_q      <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rdy_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      ps_q      <= ps_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rdy_q     <= rdy_d;
      tmo_q     <= tmo_d;
    end
  assign readyForTransferOut = rdy_q;
  assign dataWord            = word_q;
  assign dataValid           = valid_q;
  assign frameError          = ferr_q;
  assign ps                  = ps_q;
  assign bitCount            = bit_cnt_q;
endmodule

// File: tb/tb_scanner_receiver.sv
// tb_scanner_receiver: directed self-checking bench for scanner_receiver
module tb_scanner_receiver;
  logic clk = 1'b0, rst = 1'b1;
  logic serialClkIn = 1'b0, serialDataIn = 1'b0, consume = 1'b0;
  logic readyForTransferOut, dataValid, frameError;
  logic [3:0] dataWord;
  logic [1:0] ps;
  logic [2:0] bitCount;
  int errors = 0, checks = 0;
  int pulses, first;
  always #5 clk = ~clk;
  scanner_receiver dut (
    .clk                 (clk),
    .rst                 (rst),
    .serialClkIn         (serialClkIn),
    .serialDataIn        (serialDataIn),
    .consume             (consume),
    .readyForTransferOut (readyForTransferOut),
    .dataWord            (dataWord),
    .dataValid           (dataValid),
    .frameError          (frameError),
    .ps                  (ps),
    .bitCount            (bitCount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    serialDataIn = b;
    serialClkIn  = 1'b0;
    tick(4);
    serialClkIn  = 1'b1;
    tick(4);
  endtask
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    serialClkIn = 1'b0;
    tick(2);
  endtask
  task automatic do_consume();
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("rst_ps", 32'(ps), 0);
    chk("rst_rdy", 32'(readyForTransferOut), 0);
    chk("rst_word", 32'(dataWord), 0);
    chk("rst_valid", 32'(dataValid), 0);
    chk("rst_ferr", 32'(frameError), 0);
    chk("rst_bits", 32'(bitCount), 0);
    rst = 1'b0;
    tick(1);
    chk("rdy_after_rst", 32'(readyForTransferOut), 1);
    do_consume();
    chk("consume_idle_ps", 32'(ps), 0);
    send_word(4'b0101);
    chk("w1_valid", 32'(dataValid), 1);
    chk("w1_word", 32'(dataWord), 32'h5);
    chk("w1_ps", 32'(ps), 2);
    chk("w1_rdy", 32'(readyForTransferOut), 0);
    do_consume();
    chk("flush_valid", 32'(dataValid), 0);
    chk("flush_ps", 32'(ps), 3);
    chk("flush_rdy", 32'(readyForTransferOut), 0);
    tick(1);
    chk("post_flush_ps", 32'(ps), 0);
    chk("post_flush_rdy", 32'(readyForTransferOut), 1);
    send_word(4'b1110);
    chk("w2_word", 32'(dataWord), 32'hE);
    chk("w2_valid", 32'(dataValid), 1);
    do_consume();
    tick(1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("partial_bits", 32'(bitCount), 2);
    chk("partial_ps", 32'(ps), 1);
    serialClkIn = 1'b0;
    pulses = 0;
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (frameError) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("ferr_pulses", 32'(pulses), 1);
    chk("ferr_timing", 32'(first >= 60 && first <= 66), 1);
    chk("ferr_ps", 32'(ps), 0);
    chk("ferr_bits", 32'(bitCount), 0);
    chk("ferr_word_kept", 32'(dataWord), 32'hE);
    send_word(4'b0011);
    chk("w3_word", 32'(dataWord), 32'h3);
    chk("w3_valid", 32'(dataValid), 1);
    send_word(4'b1111);
    chk("full_word", 32'(dataWord), 32'h3);
    chk("full_bits", 32'(bitCount), 0);
    chk("full_ps", 32'(ps), 2);
    serialDataIn = 1'b1;
    tick(4);
    serialClkIn = 1'b1;
    tick(2);
    do_consume();
    chk("race_ps", 32'(ps), 3);
    chk("race_bits", 32'(bitCount), 0);
    tick(1);
    chk("race_idle", 32'(ps), 0);
    chk("race_bits2", 32'(bitCount), 0);
    serialClkIn = 1'b0;
    tick(4);
    chk("race_no_capture", 32'(bitCount), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("pre_rst_bits", 32'(bitCount), 3);
    serialClkIn = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ps", 32'(ps), 0);
    chk("arst_bits", 32'(bitCount), 0);
    chk("arst_rdy", 32'(readyForTransferOut), 0);
    chk("arst_word", 32'(dataWord), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    send_word(4'b1001);
    chk("w4_word", 32'(dataWord), 32'h9);
    chk("w4_valid", 32'(dataValid), 1);
    chk("w4_ps", 32'(ps), 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
